// File: rtl/vector_pkg.sv
// Shared types and default sizes for the vector memory reader.
package vector_pkg;

    localparam int unsigned ADDRESSWIDTH_DEF = 10;
    localparam int unsigned DATAWIDTH_DEF    = 20;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StPresent,
        StDone
    } state_e;

endpackage

// File: rtl/vector_reader.sv
// Streams count_end entries from a synchronous vector RAM to the line drawer via valid/ready.
// Define VECTOR_READER_LOOP_EN to replay the same pass continuously until abort.
module vector_reader
    import vector_pkg::*;
#(
    parameter int unsigned ADDRESSWIDTH = ADDRESSWIDTH_DEF,
    parameter int unsigned DATAWIDTH    = DATAWIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDRESSWIDTH-1:0] count_end,
    output logic [ADDRESSWIDTH-1:0] mem_adr,
    output logic                    mem_rd,
    input  logic [DATAWIDTH-1:0]    mem_data,
    output logic [DATAWIDTH-1:0]    vec_data,
    output logic                    vec_valid,
    input  logic                    vec_ready,
    output logic                    busy,
    output logic                    done
);

    state_e                  state_q;
    logic [ADDRESSWIDTH-1:0] ptr_q;
    logic [ADDRESSWIDTH-1:0] end_q;
    logic [DATAWIDTH-1:0]    vec_data_q;
    logic                    vec_valid_q;
    logic                    mem_rd_q;
    logic                    busy_q;
    logic                    done_q;

    // One extra bit so the last-entry compare cannot alias through a wrap.
    logic [ADDRESSWIDTH:0] ptr_inc;
    assign ptr_inc = {1'b0, ptr_q} + {{ADDRESSWIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            end_q       <= '0;
            vec_data_q  <= '0;
            vec_valid_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort && (state_q != StIdle)) begin
            state_q     <= StIdle;
            vec_valid_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        end_q  <= count_end;
                        ptr_q  <= '0;
                        busy_q <= 1'b1;
                        if (count_end != '0) begin
                            state_q  <= StRead;
                            mem_rd_q <= 1'b1;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    mem_rd_q <= 1'b0;
                    state_q  <= StWait;
                end
                StWait: begin
                    vec_data_q  <= mem_data;
                    vec_valid_q <= 1'b1;
                    state_q     <= StPresent;
                end
                StPresent: begin
                    if (vec_ready) begin
                        vec_valid_q <= 1'b0;
                        if (ptr_inc == {1'b0, end_q}) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            ptr_q    <= ptr_inc[ADDRESSWIDTH-1:0];
                            state_q  <= StRead;
                            mem_rd_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    done_q <= 1'b0;
`ifdef VECTOR_READER_LOOP_EN
                    // An empty pass has nothing to replay.
                    if (end_q != '0) begin
                        ptr_q    <= '0;
                        state_q  <= StRead;
                        mem_rd_q <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
`else
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
`endif
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_adr   = ptr_q;
    assign mem_rd    = mem_rd_q;
    assign vec_data  = vec_data_q;
    assign vec_valid = vec_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vector_reader.sv
// Scoreboard bench for vector_reader: a RAM model feeds the DUT, expected reads/entries are queued.
module tb_vector_reader;
    import vector_pkg::*;

    localparam int AW = 10;
    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] count_end = '0;
    logic [AW-1:0] mem_adr;
    logic          mem_rd;
    logic [DW-1:0] mem_data = '0;
    logic [DW-1:0] vec_data;
    logic          vec_valid;
    logic          vec_ready = 1'b1;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    vector_reader #(
        .ADDRESSWIDTH(AW),
        .DATAWIDTH   (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .count_end(count_end),
        .mem_adr  (mem_adr),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .vec_data (vec_data),
        .vec_valid(vec_valid),
        .vec_ready(vec_ready),
        .busy     (busy),
        .done     (done)
    );

    logic [DW-1:0] ram [2**AW];
    always @(posedge clk) if (mem_rd) mem_data <= ram[mem_adr];

    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [AW-1:0] adr_q[$];
    logic [DW-1:0] data_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: every read and every handshake must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (mem_rd) begin
                if (adr_q.size() == 0) check("rd_unexpected", 32'(mem_adr), 32'hffff_ffff);
                else check("rd_adr", 32'(mem_adr), 32'(adr_q.pop_front()));
            end
            if (vec_valid && vec_ready) begin
                if (data_q.size() == 0) check("vec_unexpected", 32'(vec_data), 32'hffff_ffff);
                else check("vec_data", 32'(vec_data), 32'(data_q.pop_front()));
            end
        end
    end

    task automatic start_pass(input int cnt, input int nexp);
        for (int i = 0; i < nexp; i++) begin
            adr_q.push_back(AW'(i));
            data_q.push_back(ram[i]);
        end
        @(posedge clk); #1;
        count_end = AW'(cnt);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int k = 0; k < budget && busy; k++) @(negedge clk);
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        for (int k = 0; k < budget && !vec_valid; k++) @(negedge clk);
        check(tag, 32'(vec_valid), 32'd1);
    endtask

    task automatic queues_empty(input string tag);
        check(tag, 32'(adr_q.size() + data_q.size()), 32'd0);
    endtask

    int d0;

    initial begin
        for (int i = 0; i < 2**AW; i++) ram[i] = DW'($urandom);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(vec_valid), 32'd0);
        check("rst_rd", 32'(mem_rd), 32'd0);
        check("rst_adr", 32'(mem_adr), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

`ifdef VECTOR_READER_LOOP_EN
        // Replay of a two-entry pass: 0,1,0,1 with done after each pair, then abort.
        vec_ready = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 2; i++) begin
                adr_q.push_back(AW'(i));
                data_q.push_back(ram[i]);
            end
        @(posedge clk); #1;
        count_end = AW'(2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 100 && seen < 2; k++) begin
                @(negedge clk);
                if (done) seen++;
            end
            check("loop_dones", 32'(seen), 32'd2);
            check("loop_busy", 32'(busy), 32'd1);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("loop_abort_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        queues_empty("loop_queues");
        check("loop_idle_rd", 32'(mem_rd), 32'd0);
`else
        // Three entries with ready high, including start-to-valid latency.
        d0 = done_cnt;
        vec_ready = 1'b1;
        start_pass(3, 3);
        check("t1_read_rd", 32'(mem_rd), 32'd1);
        check("t1_read_valid", 32'(vec_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_wait_valid", 32'(vec_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_lat_valid", 32'(vec_valid), 32'd1);
        check("t1_lat_data", 32'(vec_data), 32'(ram[0]));
        wait_idle(50, "t1_idle");
        queues_empty("t1_queues");
        check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Empty pass: straight to done, no read.
        d0 = done_cnt;
        start_pass(0, 0);
        check("t2_done", 32'(done), 32'd1);
        check("t2_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("t2_done_fall", 32'(done), 32'd0);
        check("t2_busy_fall", 32'(busy), 32'd0);
        check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Backpressure on entry 0 for five cycles.
        vec_ready = 1'b0;
        start_pass(2, 2);
        wait_valid(20, "t3_valid");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(vec_valid), 32'd1);
            check("t3_hold_data", 32'(vec_data), 32'(ram[0]));
            check("t3_hold_adr", 32'(mem_adr), 32'd0);
        end
        @(posedge clk); #1;
        vec_ready = 1'b1;
        wait_idle(50, "t3_idle");
        queues_empty("t3_queues");

        // Abort while entry 1 of 4 is presented.
        d0 = done_cnt;
        vec_ready = 1'b0;
        start_pass(4, 4);
        wait_valid(20, "t4_valid0");
        @(posedge clk); #1;
        vec_ready = 1'b1;
        @(posedge clk); #1;
        vec_ready = 1'b0;
        wait_valid(20, "t4_valid1");
        check("t4_adr1", 32'(mem_adr), 32'd1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t4_abort_valid", 32'(vec_valid), 32'd0);
        check("t4_abort_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        check("t4_left_adr", 32'(adr_q.size()), 32'd2);
        check("t4_left_data", 32'(data_q.size()), 32'd3);
        adr_q.delete();
        data_q.delete();
        vec_ready = 1'b1;

        // count_end changes mid-pass.
        d0 = done_cnt;
        start_pass(4, 4);
        count_end = AW'(1);
        wait_idle(80, "t5_idle");
        queues_empty("t5_queues");
        check("t5_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Reset during the WAIT of entry 1.
        start_pass(3, 3);
        repeat (4) @(posedge clk);
        #1;
        check("t6_pre_adr", 32'(mem_adr), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_adr", 32'(mem_adr), 32'd0);
        check("t6_rst_valid", 32'(vec_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_rd", 32'(mem_rd), 32'd0);
        check("t6_rst_data", 32'(vec_data), 32'd0);
        adr_q.delete();
        data_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (4) @(posedge clk);
        #1;
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        start_pass(2, 2);
        wait_idle(50, "t6_idle");
        queues_empty("t6_queues");
        check("t6_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Full-range pass: addresses 0..2^AW-2, pointer must not wrap.
        start_pass(2**AW - 1, 2**AW - 1);
        wait_idle(4000, "t7_idle");
        queues_empty("t7_queues");
        check("t7_last_adr", 32'(mem_adr), 32'(2**AW - 2));
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
